// File: rtl/pico_bridge_pkg.sv
// Shared types and constants for the PicoRV32 native-memory to AXI-lite bridge.
// No logic here, so no latency.
// No flow control here either.
package pico_bridge_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } bridge_state_e;

  // AXI protection encodings: bit 2 marks an instruction access
  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

endpackage

// File: rtl/pico_bridge_watchdog.sv
// Per-transaction watchdog: counts busy cycles and flags when the limit is hit.
// expired_o is combinational and rises during the TIMEOUT_CYCLES-th enabled cycle.
// No backpressure; a TIMEOUT_CYCLES of 0 disables the watchdog.
module pico_bridge_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // The cycle that would take the count to the limit is the expiry cycle
  assign expired_o = ENABLED && en_i && (cnt_q == LAST);

  // Next count: clear wins, then count up while enabled, holding at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pico_mem_axi_bridge.sv
// Bridges the PicoRV32 native memory port onto an AXI-lite master, one transaction at a time.
// mem_ready pulses one cycle after the R or B handshake; AXI valids come up the cycle after the request is latched.
// Waits indefinitely on AXI ready/valid until the watchdog fires; a timeout parks in ERROR until reset.
module pico_mem_axi_bridge
  import pico_bridge_pkg::*;
#(
  parameter int NODE_ID        = 0,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  res,
  // native memory port
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_rdata,
  // AXI-lite master
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  // status
  output logic                  bus_err,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic [7:0]            node_id_o,
  output logic [ADDR_W-1:0]     cur_addr_for_sim
);

  bridge_state_e         state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  instr_q, instr_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  ar_hs, aw_hs, w_hs;
  logic                  wd_en, wd_clr, wd_expired;
  logic                  unused_resp;

  // Response codes carry no information this bridge acts on
  assign unused_resp = ^{m_axi_rresp, m_axi_bresp};

  // Channel controls decode straight from registered state, so they are glitch-free
  assign m_axi_arvalid = (state_q == RADDR);
  assign m_axi_rready  = (state_q == RDATA);
  assign m_axi_awvalid = (state_q == WREQ) && aw_pend_q;
  assign m_axi_wvalid  = (state_q == WREQ) && w_pend_q;
  assign m_axi_bready  = (state_q == WRESP);
  assign mem_ready     = (state_q == DONE);
  assign bus_err       = (state_q == ERROR);

  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_arprot  = instr_q ? PROT_INSTR : PROT_DATA;
  assign m_axi_awprot  = PROT_DATA;

  assign mem_rdata        = rdata_q;
  assign rd_cnt           = rd_cnt_q;
  assign wr_cnt           = wr_cnt_q;
  assign node_id_o        = 8'(NODE_ID);
  assign cur_addr_for_sim = addr_q;

  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  // Watchdog runs across every bus-waiting state of one transaction
  assign wd_clr = (state_q == IDLE);
  assign wd_en  = (state_q == RADDR) || (state_q == RDATA) ||
                  (state_q == WREQ)  || (state_q == WRESP);

  pico_bridge_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (res),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  // Next-state and datapath update; an expiring watchdog overrides any handshake this cycle
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          instr_d   = mem_instr;
          aw_pend_d = |mem_wstrb;
          w_pend_d  = |mem_wstrb;
          state_d   = (|mem_wstrb) ? WREQ : RADDR;
        end
      end
      RADDR: begin
        if (wd_expired)  state_d = ERROR;
        else if (ar_hs)  state_d = RDATA;
      end
      RDATA: begin
        if (wd_expired) begin
          state_d = ERROR;
        end else if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          if (!(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
          state_d = DONE;
        end
      end
      WREQ: begin
        if (wd_expired) begin
          state_d = ERROR;
        end else begin
          aw_pend_d = aw_pend_q && !aw_hs;
          w_pend_d  = w_pend_q && !w_hs;
          if (!aw_pend_d && !w_pend_d) state_d = WRESP;
        end
      end
      WRESP: begin
        if (wd_expired) begin
          state_d = ERROR;
        end else if (m_axi_bvalid) begin
          if (!(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_pico_mem_axi_bridge.sv
// Self-checking bench for pico_mem_axi_bridge with a reactive AXI-lite slave.
// Expected bus activity comes from a per-transaction cycle timeline derived from slave delays.
// Slave delays are randomized, including ones long enough to trip the 8-cycle watchdog.
module tb_pico_mem_axi_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        bus_err;
  logic [1:0]  rd_cnt, wr_cnt;
  logic [7:0]  node_id;
  logic [31:0] cur_addr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata;
  int          n_rd, n_wr;

  always #5 clk = ~clk;

  pico_mem_axi_bridge #(
    .NODE_ID(32'h15A), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(2)
  ) dut (
    .clk(clk), .res(res),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(2'b00),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(2'b00),
    .bus_err(bus_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .node_id_o(node_id),
    .cur_addr_for_sim(cur_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_instr = 1'b0; mem_wstrb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_chan", 64'({arvalid, rready, awvalid, wvalid, bready, mem_ready, bus_err}), 64'(0));
    chk("rst_rdata", 64'(mem_rdata), 64'(0));
    chk("rst_cnt", 64'({rd_cnt, wr_cnt}), 64'(0));
    chk("rst_addr", 64'(cur_addr), 64'(0));
    chk("node_id", 64'(node_id), 64'(8'h5A));
    res = 1'b0;
    exp_rdata = '0; n_rd = 0; n_wr = 0;
  endtask

  // One native request against a slave that answers each channel after a fixed delay.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [3:0] strb, input bit instr, input logic [31:0] rdat,
                         input int ad, input int rd, input int awd, input int wd, input int bd,
                         output bit timed_out);
    int m, busy, ncyc, ready_cnt;
    int ak, rk, awk, wk, bk;
    logic [6:0] exp_ch;
    m = (awd > wd) ? awd : wd;
    busy = wr ? (m + bd + 2) : (ad + rd + 2);
    timed_out = (busy >= TO);
    ncyc = timed_out ? (TO + 3) : (busy + 3);
    ready_cnt = 0; ak = 0; rk = 0; awk = 0; wk = 0; bk = 0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdat;
    mem_wstrb = wr ? strb : 4'h0; mem_instr = instr;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (timed_out && c > TO)
        exp_ch = 7'b0000001;
      else if (!wr)
        exp_ch = {c <= ad + 1, (c >= ad + 2) && (c <= ad + rd + 2), 3'b000, c == busy + 1, 1'b0};
      else
        exp_ch = {2'b00, c <= awd + 1, c <= wd + 1, (c >= m + 2) && (c <= m + bd + 2),
                  c == busy + 1, 1'b0};
      chk("chan", 64'({arvalid, rready, awvalid, wvalid, bready, mem_ready, bus_err}), 64'(exp_ch));
      if (mem_ready) begin
        ready_cnt++;
        mem_valid = 1'b0;
      end
      if (arvalid) chk("ar_fields", 64'({araddr, arprot}), 64'({addr, instr ? 3'b100 : 3'b000}));
      if (awvalid) chk("aw_fields", 64'({awaddr, awprot}), 64'({addr, 3'b000}));
      if (wvalid)  chk("w_fields", 64'({wdata, wstrb}), 64'({wdat, strb}));
      if (arvalid) ak++;
      arready = arvalid && (ak > ad);
      if (rready) rk++;
      rvalid = rready && (rk > rd);
      rdata = rdat;
      if (awvalid) awk++;
      awready = awvalid && (awk > awd);
      if (wvalid) wk++;
      wready = wvalid && (wk > wd);
      if (bready) bk++;
      bvalid = bready && (bk > bd);
    end
    idle_inputs();
    if (!timed_out) begin
      if (wr) n_wr++;
      else begin
        n_rd++;
        exp_rdata = rdat;
      end
    end
    chk("ready_pulses", 64'(ready_cnt), 64'(timed_out ? 0 : 1));
    chk("mem_rdata", 64'(mem_rdata), 64'(exp_rdata));
    chk("counters", 64'({rd_cnt, wr_cnt}), 64'({sat2(n_rd), sat2(n_wr)}));
    chk("cur_addr", 64'(cur_addr), 64'(addr));
    chk("bus_err", 64'(bus_err), 64'(timed_out));
  endtask

  initial begin
    bit to;
    do_reset();

    // Read 0x100, arready immediate, rvalid two cycles after the AR handshake
    run_txn(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 0, 2, 0, 0, 0, to);
    // Write 0x200, wready three cycles after awready; read data must survive
    run_txn(1'b1, 32'h200, 32'h12345678, 4'hF, 1'b0, 32'h0, 0, 0, 0, 3, 1, to);
    // Instruction fetch then data read: arprot follows mem_instr
    run_txn(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'hCAFE0001, 1, 0, 0, 0, 0, to);
    run_txn(1'b0, 32'h404, 32'h0, 4'h0, 1'b0, 32'hCAFE0002, 0, 1, 0, 0, 0, to);
    // Awready late, wready early, both the same cycle on other edge cases
    run_txn(1'b1, 32'h208, 32'hA5A5A5A5, 4'h3, 1'b0, 32'h0, 0, 0, 2, 0, 0, to);

    // Reset while waiting in the read-data phase
    mem_valid = 1'b1; mem_addr = 32'h300; mem_wstrb = 4'h0; mem_instr = 1'b0;
    @(negedge clk);
    chk("abort_ar", 64'(arvalid), 64'(1));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("abort_rdata_phase", 64'(rready), 64'(1));
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ready", 64'({mem_ready, rready, arvalid}), 64'(0));
    end
    run_txn(1'b0, 32'h304, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 0, 0, 0, 0, 0, to);

    // Five reads on a 2-bit counter: 1, 2, 3, 3, 3
    do_reset();
    for (int i = 0; i < 5; i++)
      run_txn(1'b0, 32'h500 + 32'(i * 4), 32'h0, 4'h0, 1'b0, $urandom, 0, 0, 0, 0, 0, to);

    // Arready never comes: eight RADDR cycles, then ERROR; late arready is ignored
    run_txn(1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 32'h11111111, 99, 0, 0, 0, 0, to);
    arready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", 64'({bus_err, arvalid, mem_ready}), 64'(3'b100));
    end
    do_reset();
    // Handshake coinciding with the last allowed cycle loses to the timeout
    run_txn(1'b0, 32'h700, 32'h0, 4'h0, 1'b0, 32'h22222222, 5, 1, 0, 0, 0, to);
    do_reset();
    run_txn(1'b0, 32'h704, 32'h0, 4'h0, 1'b0, 32'h33333333, 5, 0, 0, 0, 0, to);

    // Randomized mix; long delays trip the watchdog and force a reset
    for (int i = 0; i < 40; i++) begin
      bit          w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = $urandom & 32'hFFFF_FFFC;
      run_txn(w, a, $urandom, 4'($urandom_range(1, 15)), w ? 1'b0 : 1'($urandom_range(0, 1)),
              $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), to);
      if (to) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_mem_axi_bridge.md
PICO_MEM_AXI_BRIDGE -- requirements
Module: pico_mem_axi_bridge

Interface
REQ-001 Parameter NODE_ID, default 0: node index, drives node_id_o.
REQ-002 Parameter ADDR_W, default 32: address width of native and AXI-lite ports.
REQ-003 Parameter DATA_W, default 32: data width; WSTRB width is DATA_W/8.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit per transaction; 0 disables the watchdog.
REQ-005 Parameter CNT_W, default 16: width of the transaction counters.
REQ-006 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-007 Port res, input, 1: asynchronous active-high reset.
REQ-008 Port mem_valid / mem_instr, input, 1 each: core request; instruction fetch.
REQ-009 Port mem_addr, input, ADDR_W; mem_wdata, input, DATA_W; mem_wstrb, input, DATA_W/8: request fields; wstrb==0 means read.
REQ-010 Port mem_ready, output, 1; mem_rdata, output, DATA_W: completion pulse and read data.
REQ-011 Port m_axi, if_axi_light.master: AXI-lite master (aw/w/b/ar/r channels, awprot/arprot).
REQ-012 Ports bus_err, output, 1; rd_cnt / wr_cnt, output, CNT_W each; node_id_o, output, 8; cur_addr_for_sim, output, ADDR_W.

Function
REQ-013 FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE, ERROR.
REQ-014 IDLE with mem_valid=1 latches addr/wdata/wstrb/instr and goes to RADDR if wstrb==0, else WREQ.
REQ-015 RADDR: arvalid=1 (registered, first cycle after latch); on arvalid&&arready go to RDATA.
REQ-016 RDATA: rready=1; on rvalid, latch rdata into mem_rdata and go to DONE.
REQ-017 WREQ: awvalid and wvalid both asserted on entry; each drops independently after its own handshake; go to WRESP once both handshakes have occurred, including both in the same cycle.
REQ-018 WRESP: bready=1; on bvalid go to DONE.
REQ-019 DONE: mem_ready=1 for exactly one cycle, then IDLE; mem_valid is not sampled during DONE.
REQ-020 mem_rdata holds its last read value until the next R handshake; writes do not alter it.
REQ-021 arprot = {mem_instr latched, 2'b00}; awprot = 3'b000.
REQ-022 araddr/awaddr/wdata/wstrb come from the latched registers and stay stable while their valid is high.
REQ-023 Watchdog: counter cleared on leaving IDLE, incremented each cycle in RADDR/RDATA/WREQ/WRESP; on reaching TIMEOUT_CYCLES, the FSM goes to ERROR instead of its normal next state; a handshake in the same cycle loses to the timeout.
REQ-024 ERROR: all AXI valid/ready outputs 0, mem_ready=0, bus_err=1; exit only by reset.
REQ-025 rd_cnt increments per R handshake and wr_cnt per B handshake; both saturate at all-ones.
REQ-026 cur_addr_for_sim = latched address; node_id_o = NODE_ID[7:0].
REQ-027 AXI RRESP/BRESP are ignored; a data-bearing error is outside this block's scope.

Reset
REQ-028 On res: state=IDLE, every AXI valid/ready=0, mem_ready=0, mem_rdata=0, bus_err=0, counters=0, watchdog=0, latched fields=0.
REQ-029 Reset asserted mid-transaction aborts immediately; no mem_ready is issued for the aborted request.

Structure
REQ-030 Package pico_bridge_pkg holds the state enum typedef and the AXI prot constants (PROT_DATA=3'b000, PROT_INSTR=3'b100).
REQ-031 Sub-module pico_bridge_watchdog holds the TIMEOUT_CYCLES counter, with clear/enable inputs and an expired output; everything else is flat.

Verification
REQ-032 Read 0x100, arready immediate, rvalid 2 cycles later with 0xDEADBEEF -> mem_ready one cycle after the R handshake, mem_rdata=0xDEADBEEF, rd_cnt=1.
REQ-033 Write 0x200 data 0x12345678 wstrb 0xF, wready 3 cycles after awready -> awvalid drops first, wvalid holds until its handshake, single mem_ready after bvalid, wr_cnt=1.
REQ-034 Fetch with mem_instr=1 -> arprot=3'b100; data read -> arprot=3'b000.
REQ-035 TIMEOUT_CYCLES=8 and arready held low -> ERROR after 8 cycles in RADDR, bus_err=1, arvalid=0, no mem_ready; later arready ignored.
REQ-036 Reset in RDATA, then a new read -> no stale mem_ready; fresh read completes normally; counters restart at 0.
REQ-037 CNT_W=2 with 5 reads -> rd_cnt sticks at 3.
